// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU (P0) and debug/loader (P1).
// Define DMEM_ARB_LOCK_LIMIT_EN to cap locked bursts at LOCK_MAX granted beats.
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    if (LOCK_MAX < 1 || LOCK_MAX > 255) begin : g_bad_lock_max
        $error("LOCK_MAX must be in 1..255");
    end

    typedef enum logic [1:0] {StArb, StLock0, StLock1} state_e;

    state_e state_q, state_d;
    logic   last_win_q, last_win_d;  // 0 = P0 won last, 1 = P1 won last
    logic   rd_pend_q, rd_pend_d;
    logic   rd_owner_q, rd_owner_d;
    logic   gnt0, gnt1;

`ifdef DMEM_ARB_LOCK_LIMIT_EN
    localparam logic [7:0] LockMax = 8'(LOCK_MAX);
    logic [7:0] beat_cnt_q, beat_cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StArb;
            last_win_q <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
`ifdef DMEM_ARB_LOCK_LIMIT_EN
            beat_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            last_win_q <= last_win_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
`ifdef DMEM_ARB_LOCK_LIMIT_EN
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        last_win_d = last_win_q;
        if (gnt0) last_win_d = 1'b0;
        if (gnt1) last_win_d = 1'b1;
        rd_pend_d  = (gnt0 && !p0_we) || (gnt1 && !p1_we);
        rd_owner_d = gnt1;
`ifdef DMEM_ARB_LOCK_LIMIT_EN
        beat_cnt_d = beat_cnt_q;
`endif
        unique case (state_q)
            StArb: begin
                if (gnt0 && p0_lock) begin
                    state_d = StLock0;
                end else if (gnt1 && p1_lock) begin
                    state_d = StLock1;
                end
`ifdef DMEM_ARB_LOCK_LIMIT_EN
                // The entry beat is the first counted beat of the burst.
                beat_cnt_d = 8'd1;
                if (LockMax == 8'd1) state_d = StArb;
`endif
            end
            StLock0: begin
                if ((gnt0 && !p0_lock) || (!p0_req && !p0_lock)) state_d = StArb;
`ifdef DMEM_ARB_LOCK_LIMIT_EN
                if (gnt0) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q + 8'd1 == LockMax) state_d = StArb;
                end
`endif
            end
            StLock1: begin
                if ((gnt1 && !p1_lock) || (!p1_req && !p1_lock)) state_d = StArb;
`ifdef DMEM_ARB_LOCK_LIMIT_EN
                if (gnt1) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q + 8'd1 == LockMax) state_d = StArb;
                end
`endif
            end
            default: state_d = StArb;
        endcase
    end

    // Grants are combinational so a requester's beat transfers in the cycle it is seen.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            unique case (state_q)
                StArb: begin
                    if (p0_req && p1_req) begin
                        gnt0 = last_win_q;
                        gnt1 = !last_win_q;
                    end else begin
                        gnt0 = p0_req;
                        gnt1 = p1_req;
                    end
                end
                StLock0: gnt0 = p0_req;
                StLock1: gnt1 = p1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        p0_gnt    = gnt0;
        p1_gnt    = gnt1;
        ram_en    = gnt0 | gnt1;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt0) begin
            ram_we    = p0_we;
            ram_addr  = p0_addr;
            ram_wdata = p0_wdata;
        end else if (gnt1) begin
            ram_we    = p1_we;
            ram_addr  = p1_addr;
            ram_wdata = p1_wdata;
        end
        p0_rvalid = rst && rd_pend_q && !rd_owner_q;
        p1_rvalid = rst && rd_pend_q && rd_owner_q;
        p0_rdata  = p0_rvalid ? ram_rdata : '0;
        p1_rdata  = p1_rvalid ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural RAM, grant checks per cycle and queued read returns.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef DMEM_ARB_LOCK_LIMIT_EN
    localparam int unsigned TbLockMax = 3;
`else
    localparam int unsigned TbLockMax = 16;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] ram     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    int            checks = 0;
    int            errors = 0;
    logic          g0, g1, en_s, we_s;
    logic [AW-1:0] a_s;
    logic [DW-1:0] w_s;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .LOCK_MAX(TbLockMax)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_lock  (p0_lock),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_gnt   (p0_gnt),
        .p0_rvalid(p0_rvalid),
        .p0_rdata (p0_rdata),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_lock  (p1_lock),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_gnt   (p1_gnt),
        .p1_rvalid(p1_rvalid),
        .p1_rdata (p1_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr[9:2]] = ram_wdata;
            else ram_rdata <= ram[ram_addr[9:2]];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && (p0_rvalid || p1_rvalid)) begin
            check_eq("rv_both", 64'(p0_rvalid & p1_rvalid), 64'd0);
            if (sb_q.size() == 0) begin
                check_eq("rv_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("rv_port", 64'(p1_rvalid), 64'(e.port));
                check_eq("rv_data", 64'(p1_rvalid ? p1_rdata : p0_rdata), 64'(e.data));
                check_eq("rv_other_rdata", 64'(p1_rvalid ? p0_rdata : p1_rdata), 64'd0);
            end
        end
    end

    task automatic push_read(input logic port, input logic [AW-1:0] addr);
        exp_t e;
        e.port = port;
        e.data = ref_mem[addr[9:2]];
        sb_q.push_back(e);
    endtask

    // One clock: sample outputs mid-cycle, update the reference on granted beats, return after the edge.
    task automatic step();
        @(negedge clk);
        g0   = p0_gnt;
        g1   = p1_gnt;
        en_s = ram_en;
        we_s = ram_we;
        a_s  = ram_addr;
        w_s  = ram_wdata;
        if (p0_gnt) begin
            if (p0_we) ref_mem[p0_addr[9:2]] = p0_wdata;
            else push_read(1'b0, p0_addr);
        end
        if (p1_gnt) begin
            if (p1_we) ref_mem[p1_addr[9:2]] = p1_wdata;
            else push_read(1'b1, p1_addr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'hA5A5_0000 | 32'(i);
            ref_mem[i] = 32'hA5A5_0000 | 32'(i);
        end
        ram[4]     = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;

        // Requests held during reset must be ignored.
        rst      = 1'b0;
        p0_req   = 1'b1; p0_we = 1'b1; p0_lock = 1'b1; p0_addr = 32'h50; p0_wdata = 32'h1111;
        p1_req   = 1'b1; p1_we = 1'b1; p1_lock = 1'b0; p1_addr = 32'h54; p1_wdata = 32'h2222;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_gnt0", 64'(p0_gnt), 64'd0);
        check_eq("rst_gnt1", 64'(p1_gnt), 64'd0);
        check_eq("rst_ram_en", 64'(ram_en), 64'd0);
        check_eq("rst_ram_we", 64'(ram_we), 64'd0);
        check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
        check_eq("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        check_eq("rst_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'd0);
        check_eq("rst_rdata", 64'(p0_rdata | p1_rdata), 64'd0);
        @(posedge clk);
        #1;
        p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0;
        p1_req = 1'b0; p1_we = 1'b0;
        rst    = 1'b1;
        step();
        check_eq("idle_en", 64'(en_s), 64'd0);
        check_eq("idle_addr", 64'(a_s), 64'd0);
        check_eq("idle_wdata", 64'(w_s), 64'd0);

        // Continuous contention alternates starting with P0.
        p0_req = 1'b1; p0_addr = 32'h20;
        p1_req = 1'b1; p1_addr = 32'h40;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("alt_p0", 64'(g0), 64'(i % 2 == 0));
            check_eq("alt_p1", 64'(g1), 64'(i % 2 == 1));
        end
        p0_req = 1'b0; p1_req = 1'b0;
        step();

        // Single P0 read.
        p0_req = 1'b1; p0_addr = 32'h10;
        step();
        check_eq("rd_gnt0", 64'(g0), 64'd1);
        check_eq("rd_gnt1", 64'(g1), 64'd0);
        check_eq("rd_addr", 64'(a_s), 64'h10);
        check_eq("rd_we", 64'(we_s), 64'd0);
        p0_req = 1'b0;
        step();
        check_eq("rd_returned", 64'(sb_q.size()), 64'd0);

`ifndef DMEM_ARB_LOCK_LIMIT_EN
        // P1 locked write burst keeps P0 out until the last beat.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h30;
        p1_req = 1'b1; p1_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p1_addr  = 32'h100 + 32'(4 * i);
            p1_wdata = 32'hC0DE_0000 + 32'(i);
            p1_lock  = (i < 3);
            step();
            check_eq("burst_p1", 64'(g1), 64'd1);
            check_eq("burst_p0", 64'(g0), 64'd0);
            check_eq("burst_addr", 64'(a_s), 64'(p1_addr));
        end
        p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0;
        step();
        check_eq("after_burst_p0", 64'(g0), 64'd1);
        p0_req = 1'b0;
        p1_req = 1'b1; p1_addr = 32'h104;
        step();
        check_eq("readback_gnt", 64'(g1), 64'd1);
        p1_req = 1'b0;
        step();
`endif

        // P0 holds the lock while idle; P1 must stay out and the RAM stays idle.
        p0_req = 1'b1; p0_we = 1'b1; p0_lock = 1'b1; p0_addr = 32'h200; p0_wdata = 32'h1234;
        step();
        check_eq("lock_entry_p0", 64'(g0), 64'd1);
        p0_req = 1'b0; p0_we = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h44;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_p1", 64'(g1), 64'd0);
            check_eq("hold_en", 64'(en_s), 64'd0);
        end
        p0_lock = 1'b0;
        step();
        check_eq("unlock_cycle_p1", 64'(g1), 64'd0);
        step();
        check_eq("after_unlock_p1", 64'(g1), 64'd1);
        p1_req = 1'b0;
        step();

        // Reset right after a granted read drops the return and restores P0 priority.
        p0_req = 1'b1; p0_addr = 32'h10;
        step();
        check_eq("pre_rst_gnt", 64'(g0), 64'd1);
        p0_req = 1'b0;
        rst    = 1'b0;
        check_eq("sb_pre_rst", 64'(sb_q.size()), 64'd1);
        @(negedge clk);
        check_eq("rst_no_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'd0);
        check_eq("rst_no_rdata", 64'(p0_rdata), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check_eq("post_rst_idle", 64'(en_s), 64'd0);
        p0_req = 1'b1; p0_addr = 32'h20;
        p1_req = 1'b1; p1_addr = 32'h40;
        step();
        check_eq("rst_tie_p0", 64'(g0), 64'd1);
        check_eq("rst_tie_p1", 64'(g1), 64'd0);
        p0_req = 1'b0;
        step();
        check_eq("rst_next_p1", 64'(g1), 64'd1);
        p1_req = 1'b0;
        step();

`ifdef DMEM_ARB_LOCK_LIMIT_EN
        // Lock limit of 3: P0 gets three beats, waiting P1 wins the fourth.
        p0_req = 1'b1; p0_we = 1'b1; p0_lock = 1'b1; p0_addr = 32'h300; p0_wdata = 32'h77;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h48;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("limit_p0", 64'(g0), 64'(i < 3));
            check_eq("limit_p1", 64'(g1), 64'(i == 3));
        end
        p0_req = 1'b0; p0_lock = 1'b0; p0_we = 1'b0;
        p1_req = 1'b0;
        step();
`endif

        step();
        step();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
